led_pattern_ctrl: RTL
=====================

Name: led_pattern_ctrl

Overview:
Controller that sequences the board's one-hot LED rotator.
- Debounces the raw active-low push button and uses each press to step through four display modes.
- A prescaler sets the stepping rate.
- Owns the one-hot light register and drives the LEDs directly: rotate left, rotate right, ping-pong bounce, hold.

Parameters:
- WIDTH, 8: number of LEDs (>= 2).
- TICK_DIV, 12_000_000: clk cycles per pattern step (>= 2).
- DEBOUNCE_CYCLES, 240_000: consecutive stable cycles needed to accept a button level change (>= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_n  in  1  raw push button, active-low, asynchronous to clk
- run  in  1  1 = prescaler counts and pattern steps; 0 = freeze pattern and prescaler
- lights  out  WIDTH  one-hot LED pattern
- mode  out  2  current mode: 0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 HOLD

Behaviour:
Reset (async, active-high), all state cleared immediately:
- lights = 1 (bit 0 only), mode = ROT_L, dir = LEFT, prescaler = 0.
- Both synchroniser flops = 1, debounced level = 1, debounce counter = 0.

Button path:
- Two-flop synchroniser on btn_n.
- Debounce counter:
  - Clears when the synced value equals the debounced level.
  - Increments while they differ.
  - When differing at count DEBOUNCE_CYCLES-1, the debounced level flips on that edge and the counter clears.
- press = the debounced level flipping 1 -> 0; it is asserted on exactly one edge.
- Release (0 -> 1) generates no event.
- Glitches shorter than DEBOUNCE_CYCLES never flip the level.
- Latency from btn_n going low to mode change: DEBOUNCE_CYCLES+2 edges, +1 for asynchronous sampling.

Mode FSM, advanced on press:
- ROT_L -> ROT_R -> BOUNCE -> HOLD -> ROT_L.
- Entering BOUNCE sets dir = LEFT.
- Every press clears the prescaler to 0.

Prescaler:
- While run = 1, counts 0..TICK_DIV-1 and wraps.
- tick is asserted when count == TICK_DIV-1 and run = 1.
- While run = 0, holds its value and no tick is generated.

Step on tick, using the mode value held before the edge:
- ROT_L: lights <= {lights[WIDTH-2:0], lights[WIDTH-1]}; wraps MSB to LSB.
- ROT_R: lights <= {lights[0], lights[WIDTH-1:1]}; wraps LSB to MSB.
- BOUNCE, dir = LEFT:
  - If lights[WIDTH-1] = 1: dir <= RIGHT and shift right.
  - Otherwise shift left.
- BOUNCE, dir = RIGHT: mirror of the above, turning at lights[0].
- No wrap ever occurs in BOUNCE.
- HOLD: lights unchanged.

Simultaneous events and invariants:
- press and tick on the same edge: press wins. Mode advances, prescaler clears, lights do not step.
- lights stays one-hot at all times. Mode changes never modify lights.
- Reset mid-step or mid-debounce: immediate return to reset values; a partially debounced press is discarded.
- mode is a direct register output; lights is a direct register output.

Decomposition:
- Package led_ctrl_pkg:
  - Mode encoding constants MODE_ROT_L/ROT_R/BOUNCE/HOLD (2 bits).
  - DIR_LEFT/DIR_RIGHT.
  - Default TICK_DIV and DEBOUNCE_CYCLES values.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES):
  - Contains the synchroniser and debounce counter.
  - Outputs the debounced level and a one-cycle press pulse.
  - Reused for any further board buttons.
- Prescaler, FSM and light register stay in led_pattern_ctrl.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3, WIDTH=8):
1. Reset then run=1, no press -> lights 0x01 -> 0x02 -> ... -> 0x80 -> 0x01, one step every 4 clks; mode=0. Assert reset mid-sequence -> lights=0x01, mode=0 immediately.
2. Hold btn_n low for 10 clks -> mode goes to 1 exactly 5 clks after the first sampled low, only once. Then lights step 0x01 -> 0x80 -> 0x40. Pulse btn_n low for 2 clks -> mode unchanged.
3. Press twice to reach BOUNCE from lights=0x01 -> 0x02, 0x04, ..., 0x80, 0x40, ..., 0x01, 0x02; never 0x00, never a wrap.
4. Press a third time (HOLD) with lights=0x10 -> lights stays 0x10 for 40 clks. Press again -> mode=0, lights resume 0x20 four clks after the press.
5. run=0 for 20 clks mid-count (prescaler=2) -> lights frozen. run=1 -> next step after exactly 2 clks.
6. Align press with tick (prescaler=3 on the press edge) -> mode advances, lights unchanged on that edge, next step 4 clks later.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared encodings and defaults for the LED pattern controller and its button front end.
package led_ctrl_pkg;

  localparam logic [1:0] MODE_ROT_L  = 2'd0;
  localparam logic [1:0] MODE_ROT_R  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_HOLD   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int unsigned TICK_DIV_DEFAULT        = 12_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 240_000;

  // Mode sequence on each button press.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    logic [1:0] n;
    case (m)
      MODE_ROT_L:  n = MODE_ROT_R;
      MODE_ROT_R:  n = MODE_BOUNCE;
      MODE_BOUNCE: n = MODE_HOLD;
      default:     n = MODE_ROT_L;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for an active-low push button;
// emits the debounced level and a one-cycle pulse on each accepted press.
module btn_debounce
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Press is decoded from the flip itself so the mode changes on the same edge.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    press   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
        press   = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// One-hot LED sequencer: button-selected mode (rotate L/R, bounce, hold)
// stepped by a run-gated prescaler.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  input  logic             run,
  output logic [WIDTH-1:0] lights,
  output logic [1:0]       mode
);

  localparam int unsigned       PW          = $clog2(TICK_DIV);
  localparam logic [PW-1:0]     PRESC_LAST  = PW'(TICK_DIV - 1);
  localparam logic [WIDTH-1:0]  LIGHTS_INIT = WIDTH'(1);

  logic             btn_level;
  logic             btn_press;
  logic             tick;

  logic [PW-1:0]    presc_q, presc_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] lights_q, lights_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_n (btn_n),
    .level (btn_level),
    .press (btn_press)
  );

  assign tick = run && (presc_q == PRESC_LAST);

  // A press takes priority over a coincident tick: the step is dropped.
  always_comb begin
    presc_d  = presc_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    lights_d = lights_q;
    if (btn_press) begin
      mode_d  = next_mode(mode_q);
      presc_d = '0;
      if (mode_d == MODE_BOUNCE) dir_d = DIR_LEFT;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        case (mode_q)
          MODE_ROT_L: lights_d = {lights_q[WIDTH-2:0], lights_q[WIDTH-1]};
          MODE_ROT_R: lights_d = {lights_q[0], lights_q[WIDTH-1:1]};
          MODE_BOUNCE: begin
            if (dir_q == DIR_LEFT) begin
              if (lights_q[WIDTH-1]) begin
                dir_d    = DIR_RIGHT;
                lights_d = lights_q >> 1;
              end else begin
                lights_d = lights_q << 1;
              end
            end else begin
              if (lights_q[0]) begin
                dir_d    = DIR_LEFT;
                lights_d = lights_q << 1;
              end else begin
                lights_d = lights_q >> 1;
              end
            end
          end
          default: lights_d = lights_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q  <= '0;
      mode_q   <= MODE_ROT_L;
      dir_q    <= DIR_LEFT;
      lights_q <= LIGHTS_INIT;
    end else begin
      presc_q  <= presc_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      lights_q <= lights_d;
    end
  end

  assign lights = lights_q;
  assign mode   = mode_q;

  a_onehot : assert property (@(posedge clk) disable iff (reset) $onehot(lights_q));
  a_press_level : assert property (@(posedge clk) disable iff (reset) btn_press |=> !btn_level);

endmodule
